// File: rtl/hack_pkg.sv
// Shared Hack datapath definitions: word width and the countdown controller states.
package hack_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dec16.sv
// Combinational decrement (a - 1 mod 2^WIDTH) as a ripple of half-subtractors, mirror of Inc16.
module dec16
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out
);

    // borrow[i] is the borrow into bit i; subtracting one injects a borrow at bit 0
    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_hs
        assign out[i] = a[i] ^ borrow[i];
        if (i + 1 < WIDTH) begin : g_borrow
            assign borrow[i+1] = ~a[i] & borrow[i];
        end
    end

endmodule

// File: rtl/down_counter16.sv
// Loadable countdown counter with one-cycle done pulse on reaching zero.
// Optional periodic mode: define DOWN_COUNTER16_AUTO_RELOAD_EN to restart from the last loaded value.
module down_counter16
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] dec_val;
    logic             done_nx;
    logic             busy_nx;

    dec16 #(.WIDTH(WIDTH)) u_dec (
        .a   (out),
        .out (dec_val)
    );

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nx;
`endif

    // Next-state logic; priority load > start > count
    always_comb begin
        state_nx = state;
        count_nx = out;
        done_nx  = 1'b0;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
        reload_nx = reload;
`endif
        if (load) begin
            count_nx = in;
            state_nx = IDLE;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
            reload_nx = in;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (out != '0) begin
                            state_nx = RUN;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (out > WIDTH'(1)) begin
                            count_nx = dec_val;
                        end else begin
                            done_nx = 1'b1;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
                            if (reload != '0) begin
                                count_nx = reload;
                            end else begin
                                count_nx = '0;
                                state_nx = IDLE;
                            end
`else
                            count_nx = '0;
                            state_nx = IDLE;
`endif
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
        busy_nx = (state_nx == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state <= state_nx;
            out   <= count_nx;
            busy  <= busy_nx;
            done  <= done_nx;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
            reload <= reload_nx;
`endif
        end
    end

endmodule

// File: tb/tb_down_counter16.sv
// Randomized and directed bench for down_counter16 against a behavioural countdown model.
module tb_down_counter16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        load;
    logic        start;
    logic        en;
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic [15:0] dec_a;
    logic [15:0] dec_out;

    always #5 clk = ~clk;

    down_counter16 dut (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .load  (load),
        .start (start),
        .en    (en),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    dec16 u_dec_alone (
        .a   (dec_a),
        .out (dec_out)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned done_seen = 0;

    // Model: the count as a plain integer, whether a countdown is running, the period value
    int          m_count  = 0;
    bit          m_run    = 1'b0;
    bit          m_done   = 1'b0;
    int          m_period = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycle(input bit r, input bit ld, input bit st, input bit e, input logic [15:0] v);
        @(negedge clk);
        reset = r; load = ld; start = st; en = e; din = v;
        m_done = 1'b0;
        if (r) begin
            m_count = 0; m_run = 1'b0; m_period = 0;
        end else if (ld) begin
            m_count = int'(v); m_run = 1'b0; m_period = int'(v);
        end else if (!m_run) begin
            if (st && m_count == 0) m_done = 1'b1;
            else if (st) m_run = 1'b1;
        end else if (e) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1'b1;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
                if (m_period != 0) m_count = m_period;
                else m_run = 1'b0;
`else
                m_run = 1'b0;
`endif
            end
        end
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        check("out", 32'(out), 32'(m_count));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0; din = '0; dec_a = '0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        check("rst_out", 32'(out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        // Reset mid-RUN
        cycle(0, 1, 0, 1, 16'd5);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("midrun_out", 32'(out), 3);
        cycle(1, 0, 0, 1, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
        check("midrun_nodone", done_seen, 0);

        // Basic count 3,2,1,0
        cycle(0, 1, 0, 1, 16'd3);
        cycle(0, 0, 1, 1, 0);
        check("basic_o3", 32'(out), 3);
        check("basic_b3", 32'(busy), 1);
        cycle(0, 0, 0, 1, 0);
        check("basic_o2", 32'(out), 2);
        cycle(0, 0, 0, 1, 0);
        check("basic_o1", 32'(out), 1);
        check("basic_d1", 32'(done), 0);
        cycle(0, 0, 0, 1, 0);
        check("basic_d0", 32'(done), 1);
`ifndef DOWN_COUNTER16_AUTO_RELOAD_EN
        check("basic_o0", 32'(out), 0);
        check("basic_b0", 32'(busy), 0);
`endif
        cycle(0, 0, 0, 1, 0);
        check("basic_dpulse", 32'(done), 0);

        // Pause after first decrement
        cycle(0, 1, 0, 0, 16'd4);
        done_seen = 0;
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0);
            check("pause_hold", 32'(out), 3);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        check("pause_dones", done_seen, 1);

        // Zero start: done pulse, no wrap
        cycle(0, 1, 0, 1, 16'd0);
        cycle(0, 0, 1, 1, 0);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        check("zero_out", 32'(out), 0);
        cycle(0, 0, 0, 1, 0);
        check("zero_dpulse", 32'(done), 0);

        // Abort a long countdown with a new load (start on the same edge ignored)
        cycle(0, 1, 0, 1, 16'hFFFF);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 1, 1, 16'd7);
        check("abort_out", 32'(out), 7);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);

        // dec16 on its own
        dec_a = 16'h0000; #1;
        check("dec_0", 32'(dec_out), 32'h0000FFFF);
        dec_a = 16'h0001; #1;
        check("dec_1", 32'(dec_out), 0);
        for (int i = 0; i < 8; i++) begin
            dec_a = 16'($urandom); #1;
            check("dec_rand", 32'(dec_out), 32'((int'(dec_a) + 65535) % 65536));
        end

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
        // Periodic mode: 2,1,2,1,... then load 0 and start
        cycle(0, 1, 0, 1, 16'd2);
        done_seen = 0;
        cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1, 0);
            check("ar_busy", 32'(busy), 1);
        end
        check("ar_dones", done_seen, 3);
        cycle(0, 1, 0, 1, 16'd0);
        cycle(0, 0, 1, 1, 0);
        check("ar_zero_done", 32'(done), 1);
        check("ar_zero_busy", 32'(busy), 0);
`endif

        // Randomized traffic, small loads so completions happen often
        for (int i = 0; i < 600; i++) begin
            bit          r  = ($urandom_range(99) < 2);
            bit          ld = ($urandom_range(99) < 8);
            bit          st = ($urandom_range(99) < 30);
            bit          e  = ($urandom_range(99) < 75);
            logic [15:0] v  = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(6));
            cycle(r, ld, st, e, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
